sdram_rd_engine: RTL and testbench

Read-side engine for the SDRAM application interface. After the write path has filled a frame region, it fetches that region word by word through `App_rd_en`/`App_rd_addr` and collects the returned `Sdr_rd_en`/`Sdr_rd_dout` words. It forwards them as a stream into the UDP transmit FIFO. It sits in the memory clock domain next to the write-side application block and paces itself from `udp_wrusedw`, so the FIFO never overflows.

---
 rtl/sdram_rd_engine_if.sv | 28 ++
 rtl/sdram_rd_engine.sv | 158 +++++++++++++++
 tb/tb_sdram_rd_engine.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_rd_engine_if.sv
// SDRAM application read-side bus between the read engine (master) and the controller (slave).
// Signal names follow the controller's existing application-port names.
interface sdram_rd_engine_if #(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  App_rd_en;
    logic [ADDR_WIDTH-1:0] App_rd_addr;
    logic                  Sdr_busy;
    logic                  Sdr_rd_en;
    logic [DATA_WIDTH-1:0] Sdr_rd_dout;

    modport master (
        output App_rd_en,
        output App_rd_addr,
        input  Sdr_busy,
        input  Sdr_rd_en,
        input  Sdr_rd_dout
    );

    modport slave (
        input  App_rd_en,
        input  App_rd_addr,
        output Sdr_busy,
        output Sdr_rd_en,
        output Sdr_rd_dout
    );
endinterface

// File: rtl/sdram_rd_engine.sv
// Burst read engine: fetches a word region from SDRAM into the UDP TX FIFO, paced by FIFO space.
// Optional RD_PATTERN_CHECK_EN adds an incrementing-pattern checker and the chk_err_cnt port.
module sdram_rd_engine #(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Sdr_init_done,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] rd_len,
    output logic                  rd_busy,
    output logic                  rd_done,
    sdram_rd_engine_if.master     sdr,
    input  logic [11:0]           udp_wrusedw,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef RD_PATTERN_CHECK_EN
    output logic [15:0]           chk_err_cnt,
`endif
    output logic                  rd_err
);

    localparam int unsigned BW = $clog2(BURST_LEN) + 1;
    localparam int unsigned CW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {StIdle, StWaitSpace, StIssue, StDrain, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] remain_q;
    logic [ADDR_WIDTH:0]   outst_q;
    logic [ADDR_WIDTH:0]   outst_d;
    logic [BW-1:0]         burst_q;
    logic [BW-1:0]         chunk;
    logic [CW-1:0]         space;
    logic [CW-1:0]         need;
    logic                  accept;
    logic                  spurious;
    logic                  ret;

`ifdef RD_PATTERN_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_q;
`endif

    assign accept   = sdr.App_rd_en && !sdr.Sdr_busy;
    assign spurious = sdr.Sdr_rd_en && (outst_q == '0);
    assign ret      = sdr.Sdr_rd_en && !spurious;
    assign chunk    = (remain_q < ADDR_WIDTH'(BURST_LEN)) ? BW'(remain_q) : BW'(BURST_LEN);
    // Reserve room for words already in flight since the FIFO level lags.
    assign space    = CW'(FIFO_DEPTH) - CW'(udp_wrusedw);
    assign need     = CW'(outst_q) + CW'(chunk);

    always_comb begin
        outst_d = outst_q;
        if (accept && !ret) begin
            outst_d = outst_q + 1'b1;
        end else if (!accept && ret) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            remain_q        <= '0;
            outst_q         <= '0;
            burst_q         <= '0;
            sdr.App_rd_en   <= 1'b0;
            sdr.App_rd_addr <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            rd_busy         <= 1'b0;
            rd_done         <= 1'b0;
            rd_err          <= 1'b0;
`ifdef RD_PATTERN_CHECK_EN
            exp_q           <= '0;
            chk_err_cnt     <= '0;
`endif
        end else begin
            out_valid <= sdr.Sdr_rd_en;
            if (sdr.Sdr_rd_en) begin
                out_data <= sdr.Sdr_rd_dout;
            end
            outst_q <= outst_d;
            rd_done <= 1'b0;
            if (spurious) begin
                rd_err <= 1'b1;
            end
`ifdef RD_PATTERN_CHECK_EN
            if (sdr.Sdr_rd_en) begin
                exp_q <= exp_q + 1'b1;
                if (sdr.Sdr_rd_dout != exp_q) begin
                    rd_err <= 1'b1;
                    if (chk_err_cnt != 16'hFFFF) begin
                        chk_err_cnt <= chk_err_cnt + 1'b1;
                    end
                end
            end
`endif
            if (state_q != StIdle && !Sdr_init_done) begin
                // Controller lost init: abandon the transfer without a completion pulse.
                state_q       <= StIdle;
                outst_q       <= '0;
                sdr.App_rd_en <= 1'b0;
                rd_busy       <= 1'b0;
                rd_err        <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rd_start && Sdr_init_done) begin
                            sdr.App_rd_addr <= rd_base;
                            remain_q        <= rd_len;
                            outst_q         <= '0;
                            rd_busy         <= 1'b1;
                            state_q         <= (rd_len == '0) ? StDone : StWaitSpace;
`ifdef RD_PATTERN_CHECK_EN
                            exp_q           <= DATA_WIDTH'(rd_base);
                            chk_err_cnt     <= '0;
`endif
                        end
                    end
                    StWaitSpace: begin
                        if (space >= need) begin
                            burst_q       <= chunk;
                            sdr.App_rd_en <= 1'b1;
                            state_q       <= StIssue;
                        end
                    end
                    StIssue: begin
                        if (accept) begin
                            sdr.App_rd_addr <= sdr.App_rd_addr + 1'b1;
                            remain_q        <= remain_q - 1'b1;
                            burst_q         <= burst_q - 1'b1;
                            if (burst_q == BW'(1)) begin
                                sdr.App_rd_en <= 1'b0;
                                state_q <= (remain_q != ADDR_WIDTH'(1)) ? StWaitSpace : StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        if (outst_d == '0) begin
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        rd_done <= 1'b1;
                        rd_busy <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_rd_engine.sv
// Directed bench for sdram_rd_engine with a fixed-latency SDRAM controller model.
// Define RD_PATTERN_CHECK_EN for both files to exercise the pattern checker.
module tb_sdram_rd_engine;

    localparam int LAT = 5;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic        clk;
    logic        rst_n;
    logic        Sdr_init_done;
    logic        rd_start;
    logic [20:0] rd_base;
    logic [20:0] rd_len;
    logic        rd_busy;
    logic        rd_done;
    logic [11:0] udp_wrusedw;
    logic        out_valid;
    logic [31:0] out_data;
    logic        rd_err;
`ifdef RD_PATTERN_CHECK_EN
    logic [15:0] chk_err_cnt;
`endif

    sdram_rd_engine_if #(.ADDR_WIDTH(21), .DATA_WIDTH(32)) sdr ();

    sdram_rd_engine #(
        .ADDR_WIDTH(21),
        .DATA_WIDTH(32),
        .BURST_LEN (16),
        .FIFO_DEPTH(4096)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Sdr_init_done(Sdr_init_done),
        .rd_start     (rd_start),
        .rd_base      (rd_base),
        .rd_len       (rd_len),
        .rd_busy      (rd_busy),
        .rd_done      (rd_done),
        .sdr          (sdr),
        .udp_wrusedw  (udp_wrusedw),
        .out_valid    (out_valid),
        .out_data     (out_data),
`ifdef RD_PATTERN_CHECK_EN
        .chk_err_cnt  (chk_err_cnt),
`endif
        .rd_err       (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_ret_cyc = 0;
    int          lat_bad = 0;
    int          hold_bad = 0;
    int          en_rise = 0;
    logic        busy_mode = 1'b0;
    logic        inject = 1'b0;
    logic        corrupt_en = 1'b0;
    logic [20:0] reqs[$];
    logic [31:0] got[$];
    ret_t        pend[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: inputs change at negedge, requests/returns are judged per whole cycle.
    initial begin
        logic        prev_en;
        logic        prev_stall;
        logic        prev_rd_en;
        logic [20:0] prev_addr;
        logic [31:0] word;
        ret_t        r;
        int          idx;
        prev_en = 1'b0;
        prev_stall = 1'b0;
        prev_rd_en = 1'b0;
        prev_addr = '0;
        sdr.Sdr_busy = 1'b0;
        sdr.Sdr_rd_en = 1'b0;
        sdr.Sdr_rd_dout = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend.delete();
                prev_en = 1'b0;
                prev_stall = 1'b0;
                prev_rd_en = 1'b0;
                sdr.Sdr_rd_en = 1'b0;
                sdr.Sdr_busy = 1'b0;
                continue;
            end
            if (out_valid !== prev_rd_en) lat_bad++;
            if (out_valid) got.push_back(out_data);
            if (rd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall && (!sdr.App_rd_en || sdr.App_rd_addr != prev_addr)) hold_bad++;
            if (sdr.App_rd_en && !prev_en) en_rise++;
            sdr.Sdr_busy = busy_mode ? cyc[0] : 1'b0;
            if (sdr.App_rd_en && !sdr.Sdr_busy) begin
                idx = reqs.size();
                word = {11'b0, sdr.App_rd_addr};
                if (corrupt_en && (idx == 5 || idx == 17 || idx == 33)) word = word + 1;
                r.due = cyc + LAT;
                r.data = word;
                pend.push_back(r);
                reqs.push_back(sdr.App_rd_addr);
            end
            prev_stall = sdr.App_rd_en && sdr.Sdr_busy;
            prev_addr = sdr.App_rd_addr;
            prev_en = sdr.App_rd_en;
            if (inject) begin
                sdr.Sdr_rd_en = 1'b1;
                sdr.Sdr_rd_dout = 32'hDEADBEEF;
                inject = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                sdr.Sdr_rd_en = 1'b1;
                sdr.Sdr_rd_dout = r.data;
                last_ret_cyc = cyc;
            end else begin
                sdr.Sdr_rd_en = 1'b0;
            end
            prev_rd_en = sdr.Sdr_rd_en;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic clear_logs();
        reqs.delete();
        got.delete();
        done_cnt = 0;
        en_rise = 0;
        lat_bad = 0;
        hold_bad = 0;
    endtask

    task automatic start_read(input logic [20:0] base, input logic [20:0] len);
        rd_base = base;
        rd_len = len;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n;
        n = 0;
        while (done_cnt == 0 && n < lim) begin
            step();
            n++;
        end
        check_val({tag, "_done_seen"}, done_cnt, 1);
    endtask

    task automatic check_stream(input string tag, input logic [20:0] base, input int len,
                                input logic chk_data);
        int          bad_a;
        int          bad_d;
        logic [20:0] e;
        bad_a = 0;
        bad_d = 0;
        check_val({tag, "_req_cnt"}, reqs.size(), len);
        check_val({tag, "_word_cnt"}, got.size(), len);
        for (int i = 0; i < len; i++) begin
            e = base + 21'(i);
            if (i >= reqs.size() || reqs[i] !== e) bad_a++;
            if (chk_data && (i >= got.size() || got[i] !== {11'b0, e})) bad_d++;
        end
        check_val({tag, "_addr_bad"}, bad_a, 0);
        if (chk_data) check_val({tag, "_data_bad"}, bad_d, 0);
        check_val({tag, "_lat_bad"}, lat_bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        Sdr_init_done = 1'b1;
        rd_start = 1'b0;
        rd_base = '0;
        rd_len = '0;
        udp_wrusedw = '0;
        #1;
        check_val("rst_en", sdr.App_rd_en, 0);
        check_val("rst_addr", sdr.App_rd_addr, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_busy", rd_busy, 0);
        check_val("rst_done", rd_done, 0);
        check_val("rst_err", rd_err, 0);
        do_reset();

        // Basic read: 16+16+8 words, latency 5.
        clear_logs();
        start_read(21'h100, 21'd40);
        check_val("basic_en_c1", sdr.App_rd_en, 0);
        check_val("basic_busy_c1", rd_busy, 1);
        step();
        check_val("basic_en_c2", sdr.App_rd_en, 1);
        wait_done("basic", 400);
        check_val("basic_done_delay", done_cyc - last_ret_cyc, 2);
        check_val("basic_busy_at_done", rd_busy, 0);
        repeat (3) step();
        check_stream("basic", 21'h100, 40, 1'b1);
        check_val("basic_bursts", en_rise, 3);
        check_val("basic_done_once", done_cnt, 1);
        check_val("basic_err", rd_err, 0);

        // Backpressure: space 11 < chunk 16 holds the engine.
        clear_logs();
        udp_wrusedw = 12'd4085;
        start_read(21'h300, 21'd16);
        repeat (10) step();
        check_val("bp_no_req", reqs.size(), 0);
        check_val("bp_no_en", en_rise, 0);
        udp_wrusedw = 12'd4000;
        step();
        if (!sdr.App_rd_en) step();
        check_val("bp_en_released", sdr.App_rd_en, 1);
        wait_done("bp", 200);
        repeat (2) step();
        check_stream("bp", 21'h300, 16, 1'b1);
        udp_wrusedw = '0;

        // Stalls every other cycle.
        clear_logs();
        busy_mode = 1'b1;
        start_read(21'h200, 21'd40);
        wait_done("stall", 600);
        repeat (2) step();
        busy_mode = 1'b0;
        check_stream("stall", 21'h200, 40, 1'b1);
        check_val("stall_hold_bad", hold_bad, 0);

        // Address wrap.
        clear_logs();
        start_read(21'h1FFFFE, 21'd4);
        wait_done("wrap", 100);
        repeat (2) step();
        check_stream("wrap", 21'h1FFFFE, 4, 1'b1);

        // Zero length.
        clear_logs();
        start_read(21'h50, 21'd0);
        check_val("zero_done_c1", rd_done, 0);
        check_val("zero_busy_c1", rd_busy, 1);
        step();
        check_val("zero_done_c2", rd_done, 1);
        check_val("zero_busy_c2", rd_busy, 0);
        repeat (3) step();
        check_val("zero_no_req", reqs.size(), 0);
        check_val("zero_err", rd_err, 0);

`ifdef RD_PATTERN_CHECK_EN
        do_reset();
        clear_logs();
        corrupt_en = 1'b1;
        start_read(21'h100, 21'd40);
        wait_done("pat", 400);
        repeat (2) step();
        corrupt_en = 1'b0;
        check_val("pat_cnt", chk_err_cnt, 3);
        check_val("pat_err", rd_err, 1);
        do_reset();
`endif

        // Spurious return in IDLE.
        check_val("spur_err_before", rd_err, 0);
        inject = 1'b1;
        step();
        step();
        check_val("spur_valid", out_valid, 1);
        check_val("spur_data", out_data, 32'hDEADBEEF);
        check_val("spur_err", rd_err, 1);

        // Init loss mid-burst.
        do_reset();
        clear_logs();
        start_read(21'h0, 21'd40);
        for (int n = 0; n < 50 && reqs.size() < 5; n++) step();
        check_val("init_reached_burst", sdr.App_rd_en, 1);
        Sdr_init_done = 1'b0;
        step();
        check_val("init_en", sdr.App_rd_en, 0);
        check_val("init_busy", rd_busy, 0);
        check_val("init_err", rd_err, 1);
        repeat (20) step();
        check_val("init_no_done", done_cnt, 0);
        Sdr_init_done = 1'b1;
        do_reset();
        check_val("final_err_cleared", rd_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
